// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, diff = (a - b) mod 2^WIDTH.
// Processes one bit per clock, LSB first, through one full-subtractor cell
// with a registered borrow. Sits behind a start/done handshake.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   start      - request, accepted in IDLE or DONE
//   a, b       - minuend / subtrahend, captured on the accepting edge
//   diff       - registered difference, updated only at completion
//   borrow_out - final borrow, 1 iff a < b
//   busy       - high while running
//   done       - one-cycle completion pulse
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic x;
  logic y;
  logic d;
  logic bo;
  logic last;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    x    = sa[0];
    y    = sb[0];
    d    = x ^ y ^ br;
    bo   = (~x & y) | (~(x ^ y) & br);
    last = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      sr         <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            sr    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= {d, sr[WIDTH-1:1]};
          br  <= bo;
          cnt <= cnt + 1'b1;
          if (last) begin
            // Publish the shifted-in final bit together with the rest of SR.
            diff       <= {d, sr[WIDTH-1:1]};
            borrow_out <= bo;
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
